ps2_keyboard: RTL and testbench

//   Receives scan codes from the board PS2 port and buffers them for the CPU.

---
 rtl/ps2_keyboard.sv | 181 ++++++++++++++++++
 tb/tb_ps2_keyboard.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard.sv
// PS/2 device-to-host receiver: synchronises the raw pins, deframes 11-bit frames
// and buffers good bytes in a first-word fall-through FIFO for the CPU.
//
// state    | meaning
// S_IDLE   | waiting for a start bit (data low on a falling edge)
// S_DATA   | shifting in 8 data bits, LSB first
// S_PARITY | capturing the odd-parity bit
// S_STOP   | checking stop bit and parity, pushing or flagging the byte
module ps2_keyboard #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_en,
    input  logic       clr_err,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic          clk_meta_q,  clk_meta_d;
    logic          clk_sync_q,  clk_sync_d;
    logic          clk_prev_q,  clk_prev_d;
    logic          data_meta_q, data_meta_d;
    logic          data_sync_q, data_sync_d;

    state_t        state_q,     state_d;
    logic [2:0]    bit_cnt_q,   bit_cnt_d;
    logic [7:0]    shift_q,     shift_d;
    logic          parity_q,    parity_d;
    logic [TW-1:0] timer_q,     timer_d;

    logic [AW:0]   wr_ptr_q,    wr_ptr_d;
    logic [AW:0]   rd_ptr_q,    rd_ptr_d;
    logic          overflow_q,  overflow_d;
    logic          frame_err_q, frame_err_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic          fall;
    logic          frame_ok;
    logic          frame_bad;
    logic          empty;
    logic          full;
    logic          do_pop;
    logic          do_push;

    always_comb begin
        clk_meta_d  = ps2_clk;
        clk_sync_d  = clk_meta_q;
        clk_prev_d  = clk_sync_q;
        data_meta_d = ps2_data;
        data_sync_d = data_meta_q;
        fall        = clk_prev_q & ~clk_sync_q;
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        timer_d   = timer_q;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;

        if (fall) begin
            timer_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (!data_sync_q) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end
                end
                S_DATA: begin
                    shift_d   = {data_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    parity_d = data_sync_q;
                    state_d  = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (data_sync_q && ((^shift_q) ^ parity_q)) begin
                        frame_ok = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q == S_IDLE) begin
            timer_d = '0;
        end else if (timer_q == TO_LAST) begin
            // Abandon a stalled partial frame silently; the device will resend.
            state_d = S_IDLE;
            timer_d = '0;
        end else begin
            timer_d = timer_q + TW'(1);
        end
    end

    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop  = rd_en && !empty;
        // A pop in the same cycle frees the slot a full FIFO needs.
        do_push = frame_ok && (!full || do_pop);

        wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

        overflow_d  = (overflow_q  & ~clr_err) | (frame_ok & full & ~do_pop);
        frame_err_d = (frame_err_q & ~clr_err) | frame_bad;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            timer_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            clk_meta_q  <= clk_meta_d;
            clk_sync_q  <= clk_sync_d;
            clk_prev_q  <= clk_prev_d;
            data_meta_q <= data_meta_d;
            data_sync_q <= data_sync_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            timer_q     <= timer_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Storage needs no reset: the head is masked to zero while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (do_push && !reset) begin
            mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
        end
    end

    assign data      = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    assign ready     = !empty;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Bench for ps2_keyboard: bit-banged PS/2 frames, a queue-based reference of the
// byte buffer and sticky flags, and a per-cycle compare of all outputs.
module tb_ps2_keyboard;
    localparam int DEPTH = 8;
    localparam int TO    = 300;
    localparam int H     = 20;

    logic       clock    = 1'b0;
    logic       reset    = 1'b1;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en    = 1'b0;
    logic       clr_err  = 1'b0;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       frame_err;

    ps2_keyboard #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rd_en     (rd_en),
        .clr_err   (clr_err),
        .data      (data),
        .ready     (ready),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  b;
        bit          good;
    } ev_t;

    ev_t         sched[$];
    logic [7:0]  mq[$];
    bit          m_ovf = 1'b0;
    bit          m_ferr = 1'b0;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    bit          cmp_en = 1'b0;
    bit          done = 1'b0;
    int          pop_permil = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: a byte lands in the buffer three clocks after the stop-bit edge
    // is driven (two sync stages plus the write edge).
    initial forever begin
        @(posedge clock);
        cyc++;
        if (reset) begin
            mq.delete();
            sched.delete();
            m_ovf  = 1'b0;
            m_ferr = 1'b0;
        end else begin
            bit  pop_ok;
            ev_t e;
            pop_ok = rd_en && (mq.size() > 0);
            if (clr_err) begin
                m_ovf  = 1'b0;
                m_ferr = 1'b0;
            end
            if (pop_ok) void'(mq.pop_front());
            if (sched.size() > 0 && sched[0].cyc == cyc) begin
                e = sched.pop_front();
                if (!e.good)                m_ferr = 1'b1;
                else if (mq.size() < DEPTH) mq.push_back(e.b);
                else                        m_ovf = 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge clock);
        if (cmp_en) begin
            chk("ready",     {7'b0, ready},     {7'b0, (mq.size() > 0)});
            chk("data",      data,              (mq.size() > 0) ? mq[0] : 8'h00);
            chk("overflow",  {7'b0, overflow},  {7'b0, m_ovf});
            chk("frame_err", {7'b0, frame_err}, {7'b0, m_ferr});
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1, "watchdog expired");
    end

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit pop_at_push);
        logic [10:0] bits;
        ev_t         e;
        bits[0]   = 1'b0;
        bits[8:1] = b;
        bits[9]   = ~(^b) ^ bad_par;
        bits[10]  = ~bad_stop;
        for (int i = 0; i < 11; i++) begin
            ps2_data = bits[i];
            repeat (H) @(negedge clock);
            ps2_clk = 1'b0;
            if (i == 10) begin
                e.cyc  = cyc + 3;
                e.b    = b;
                e.good = !bad_par && !bad_stop;
                sched.push_back(e);
            end
            if (i == 10 && pop_at_push) begin
                repeat (2) @(negedge clock);
                rd_en = 1'b1;
                @(negedge clock);
                rd_en = 1'b0;
                repeat (H - 3) @(negedge clock);
            end else begin
                repeat (H) @(negedge clock);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (H) @(negedge clock);
    endtask

    task automatic send_partial(input int nbits);
        logic [7:0] b;
        b = 8'h1C;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = (i == 0) ? 1'b0 : b[i-1];
            repeat (H) @(negedge clock);
            ps2_clk = 1'b0;
            repeat (H) @(negedge clock);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        @(negedge clock);
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clock);
        clr_err = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clock);
        reset  = 1'b0;
        cmp_en = 1'b1;
        chk("rst_ready", {7'b0, ready}, 8'h00);
        chk("rst_data", data, 8'h00);
        chk("rst_ovf", {7'b0, overflow}, 8'h00);
        chk("rst_ferr", {7'b0, frame_err}, 8'h00);

        // Single byte
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        chk("t1_ready", {7'b0, ready}, 8'h01);
        chk("t1_data", data, 8'h1C);
        pop();
        chk("t1_empty", {7'b0, ready}, 8'h00);

        // Break sequence
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        chk("t2_head", data, 8'hF0);
        pop();
        chk("t2_next", data, 8'h1C);
        pop();
        chk("t2_empty", {7'b0, ready}, 8'h00);
        chk("t2_ferr", {7'b0, frame_err}, 8'h00);

        // Bad parity, bad stop, recovery and clear
        send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
        chk("t3_ferr", {7'b0, frame_err}, 8'h01);
        chk("t3_ready", {7'b0, ready}, 8'h00);
        send_frame(8'h32, 1'b0, 1'b0, 1'b0);
        chk("t3_data", data, 8'h32);
        pulse_clr();
        chk("t3_clr", {7'b0, frame_err}, 8'h00);
        pop();
        send_frame(8'h55, 1'b0, 1'b1, 1'b0);
        chk("t3_stop_ferr", {7'b0, frame_err}, 8'h01);
        chk("t3_stop_ready", {7'b0, ready}, 8'h00);
        pulse_clr();

        // Overflow, then push into a full FIFO with a simultaneous pop
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0);
        chk("t4_ovf", {7'b0, overflow}, 8'h01);
        for (int i = 1; i <= 8; i++) begin
            chk("t4_read", data, 8'(i));
            pop();
        end
        chk("t4_empty", {7'b0, ready}, 8'h00);
        pulse_clr();
        chk("t4_ovf_clr", {7'b0, overflow}, 8'h00);
        for (int i = 0; i < 8; i++) send_frame(8'(8'h11 + i), 1'b0, 1'b0, 1'b0);
        send_frame(8'hAA, 1'b0, 1'b0, 1'b1);
        chk("t4_no_ovf", {7'b0, overflow}, 8'h00);
        chk("t4_head", data, 8'h12);
        repeat (7) pop();
        chk("t4_last", data, 8'hAA);
        pop();
        chk("t4_drained", {7'b0, ready}, 8'h00);

        // Stalled partial frame times out silently
        send_partial(5);
        repeat (TO + 50) @(negedge clock);
        chk("t5_ferr", {7'b0, frame_err}, 8'h00);
        chk("t5_ready", {7'b0, ready}, 8'h00);
        send_frame(8'h45, 1'b0, 1'b0, 1'b0);
        chk("t5_data", data, 8'h45);
        pop();

        // Reset mid-frame with a byte buffered and an error flagged
        send_frame(8'h77, 1'b0, 1'b0, 1'b0);
        send_frame(8'h10, 1'b1, 1'b0, 1'b0);
        chk("t6_pre_ready", {7'b0, ready}, 8'h01);
        send_partial(6);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("t6_ready", {7'b0, ready}, 8'h00);
        chk("t6_data", data, 8'h00);
        chk("t6_ferr", {7'b0, frame_err}, 8'h00);
        chk("t6_ovf", {7'b0, overflow}, 8'h00);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        chk("t6_data_after", data, 8'h1C);
        pop();

        // Randomised traffic with background pops and error clears
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    pop_permil = (k < 14) ? 0 : ((k < 28) ? 5 : 60);
                    send_frame(8'($urandom), $urandom_range(0, 9) == 0,
                               $urandom_range(0, 19) == 0, 1'b0);
                    repeat ($urandom_range(0, 40)) @(negedge clock);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clock);
                    rd_en   = ($urandom_range(0, 999) < pop_permil);
                    clr_err = ($urandom_range(0, 499) == 0);
                end
                rd_en   = 1'b0;
                clr_err = 1'b0;
            end
        join

        for (int i = 0; i < DEPTH + 2; i++) pop();
        chk("final_empty", {7'b0, ready}, 8'h00);
        repeat (5) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
